piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Downstream stage of the 4-bit parallel register. Accepts one WIDTH-bit word per
//  valid/ready handshake and shifts it out one bit per enabled clock.
//  Each word produces a framed serial stream with a last-bit flag.
//  Feeds serial links and bit-level test logic.
// PARAMETERS
//  WIDTH      4  word width in bits; legal range >= 2
//  LSB_FIRST  0  0: send bit WIDTH-1 first; 1: send bit 0 first
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_data    in   WIDTH  parallel word from the upstream register
//  in_valid   in   1      in_data holds a word
//  in_ready   out  1      serializer can accept a word
//  tick       in   1      bit-advance enable (baud/strobe), sampled on posedge clk
//  ser_out    out  1      current serial bit
//  ser_valid  out  1      ser_out holds a bit of a frame
//  ser_last   out  1      ser_out holds the final bit of the frame
//  busy       out  1      frame in progress (= ~in_ready)
// BEHAVIOUR
//  Reset values, applied asynchronously on rst=1:
//   - state=IDLE, shift_reg=0, bit_cnt=0
//   - ser_out=0, ser_valid=0, ser_last=0, in_ready=1, busy=0
//  States: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
//  Outputs:
//   - in_ready = (state==IDLE), combinational from state.
//   - ser_out is the MSB of shift_reg (LSB when LSB_FIRST=1); in PAR it is the parity bit.
//   - ser_valid = (state!=IDLE).
//  Load: on posedge with in_valid&&in_ready:
//   - shift_reg<=in_data, bit_cnt<=0, state<=SHIFT.
//   - tick is ignored on the load cycle.
//  Latency: the first bit appears on ser_out in the cycle after acceptance.
//  SHIFT: on posedge with tick=1, the current bit is consumed:
//   - shift_reg shifts one place toward the output end, zero-filled.
//   - bit_cnt increments.
//   - tick=0 holds all state; each bit is held indefinitely.
//  ser_last = 1 in SHIFT when bit_cnt==WIDTH-1 (no PARITY_EN), or in PAR.
//  Frame end: tick on the last bit goes to IDLE; in_ready rises the next cycle.
//   - Minimum gap between frames is 1 clock (the IDLE cycle).
//  Back-pressure and input stability:
//   - in_data and in_valid are ignored while busy; a word is never overwritten or dropped.
//   - in_valid may drop without acceptance; nothing is latched.
//  Frame length is exactly WIDTH ticks (WIDTH+1 with PARITY_EN).
//  bit_cnt width is $clog2(WIDTH+1); it never wraps within a frame.
//  Reset mid-frame aborts the frame immediately with no further serial bits.
//   - The partial frame is not resumed after reset.
// CONFIGURATION
//  PARITY_EN defined:
//   - Even parity (^in_data) is captured at load into a parity register.
//   - After the WIDTH data bits, state goes to PAR for one tick period.
//   - In PAR: ser_out=parity, ser_last=1. A tick in PAR goes to IDLE.
//  PARITY_EN undefined:
//   - No PAR state and no parity register.
//   - The frame is data-only; SHIFT goes to IDLE on the last tick.
// TESTING
//  1 rst=1 mid-sim -> all outputs at reset values immediately; in_ready=1 after release.
//  2 in_data=4'b1011, tick always 1, LSB_FIRST=0 -> ser_out 1,0,1,1 on 4 cycles;
//    ser_last only on 4th; in_ready=1 on cycle 6.
//  3 LSB_FIRST=1, in_data=4'b1000, tick every 3rd clk -> 0,0,0,1, each bit held 3 clks;
//    ser_valid continuous.
//  4 in_valid held high with two words A then B, B presented while busy ->
//    B accepted only after A's 4th bit plus 1 IDLE clk; B unchanged on output.
//  5 rst pulse after 2nd bit of 4'b1111 -> ser_valid=0 at once;
//    next word 4'b0001 sent cleanly.
//  6 PARITY_EN, in_data=4'b0111 -> 0,1,1,1 then parity 1 with ser_last=1; 5 ticks total.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out stage with a valid/ready word input.
// Each accepted WIDTH-bit word is sent one bit per tick. The last bit of the frame
// is flagged with ser_last. The bit order is selected by LSB_FIRST.
// Optional feature macro: PARITY_EN. When it is defined, an even-parity bit is sent
// after the data bits as the final bit of the frame.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = SHIFT, 2 = PAR.

module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             tick,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
    // in_ready depends only on the FSM state, never on in_valid. While busy, in_data
    // and in_valid are ignored. A held word therefore waits, and is neither dropped
    // nor overwritten. in_valid may be withdrawn before transfer without effect.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef PARITY_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
`ifdef PARITY_EN
    logic             parity;
`endif

    // Frame FSM: load on handshake, consume one bit per tick, return to IDLE after the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // tick is deliberately ignored here; the first bit must be visible for a full tick period
                    if (in_valid) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
`ifdef PARITY_EN
                        parity    <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        // Move the next bit to the output end; vacated positions fill with zero
                        if (LSB_FIRST) begin
                            shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                        end else begin
                            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        end
                        // bit_cnt reaches WIDTH at most, which fits in CNT_W bits, so it never wraps
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_IDX) begin
`ifdef PARITY_EN
                            state <= PAR;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from registered state; the data bit is taken from the output end of shift_reg
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        ser_valid = (state != IDLE);
        state_dbg = state;
        ser_out   = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
`ifdef PARITY_EN
        ser_last  = (state == PAR);
        if (state == PAR) begin
            ser_out = parity;
        end
`else
        ser_last  = (state == SHIFT) && (bit_cnt == LAST_IDX);
`endif
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer.
// It drives two instances from the same inputs: an MSB-first instance (_m) and an
// LSB-first instance (_l). Outputs are sampled and inputs are changed on the falling
// edge. Expected bits come from the hand-written vectors below, through exp_q.

module tb_piso_serializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         tick     = 1'b0;

    logic       in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
    logic       in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
    logic [1:0] state_m, state_l;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .tick(tick), .ser_out(ser_out_m),
        .ser_valid(ser_valid_m), .ser_last(ser_last_m), .busy(busy_m),
        .state_dbg(state_m)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .tick(tick), .ser_out(ser_out_l),
        .ser_valid(ser_valid_l), .ser_last(ser_last_l), .busy(busy_l),
        .state_dbg(state_l)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {expected MSB-first bit, expected LSB-first bit}.
    logic [1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid_m"}, ser_valid_m, 1'b0);
        check({tag, "_valid_l"}, ser_valid_l, 1'b0);
        check({tag, "_last_m"},  ser_last_m,  1'b0);
        check({tag, "_last_l"},  ser_last_l,  1'b0);
        check({tag, "_out_m"},   ser_out_m,   1'b0);
        check({tag, "_out_l"},   ser_out_l,   1'b0);
        check({tag, "_ready_m"}, in_ready_m,  1'b1);
        check({tag, "_ready_l"}, in_ready_l,  1'b1);
        check({tag, "_busy_m"},  busy_m,      1'b0);
        check({tag, "_busy_l"},  busy_l,      1'b0);
        check({tag, "_state_m"}, state_m,     2'd0);
    endtask

    task automatic check_bit(input string tag, input logic [1:0] e, input logic last);
        check({tag, "_out_m"},   ser_out_m,   e[1]);
        check({tag, "_out_l"},   ser_out_l,   e[0]);
        check({tag, "_valid_m"}, ser_valid_m, 1'b1);
        check({tag, "_valid_l"}, ser_valid_l, 1'b1);
        check({tag, "_last_m"},  ser_last_m,  last);
        check({tag, "_last_l"},  ser_last_l,  last);
        check({tag, "_ready_m"}, in_ready_m,  1'b0);
        check({tag, "_busy_m"},  busy_m,      1'b1);
    endtask

    task automatic load_expected(input logic [W-1:0] word);
        exp_q.delete();
        for (int b = 0; b < W; b++) begin
            exp_q.push_back({word[W-1-b], word[b]});
        end
`ifdef PARITY_EN
        exp_q.push_back({^word, ^word});
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(in_ready_m && in_ready_l) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, in_ready_m && in_ready_l, 1'b1);
    endtask

    // Presents word with tick=1 on the load cycle, which must be ignored. While busy,
    // the task drives busy_data/busy_valid, and it checks every hold cycle of every bit.
    task automatic run_frame(input string tag, input logic [W-1:0] word, input int period,
                             input logic [W-1:0] busy_data, input logic busy_valid);
        logic [1:0] e;
        wait_ready(tag);
        in_data  = word;
        in_valid = 1'b1;
        tick     = 1'b1;
        load_expected(word);
        @(negedge clk);
        in_data  = busy_data;
        in_valid = busy_valid;
        for (int b = 0; b < NBITS; b++) begin
            e = exp_q.pop_front();
            for (int h = 0; h < period; h++) begin
                check_bit($sformatf("%s_b%0d_h%0d", tag, b, h), e, (b == NBITS - 1));
                tick = (h == period - 1);
                @(negedge clk);
            end
        end
        tick = 1'b0;
        check_idle({tag, "_end"});
    endtask

    task automatic reset_mid_frame(input string tag);
        wait_ready(tag);
        in_data  = 4'b1111;
        in_valid = 1'b1;
        tick     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        tick     = 1'b1;
        check_bit({tag, "_b0"}, 2'b11, 1'b0);
        @(negedge clk);
        check_bit({tag, "_b1"}, 2'b11, 1'b0);
        @(negedge clk);
        // Two bits consumed, third showing: pulse reset between edges
        rst = 1'b1;
        #1;
        check_idle({tag, "_async"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle({tag, "_release"});
        @(negedge clk);
        tick = 1'b0;
        check_idle({tag, "_no_resume"});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1;
        check_idle("reset_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        run_frame("t2_1011", 4'b1011, 1, 4'b0100, 1'b0);
        run_frame("t3_1000", 4'b1000, 3, 4'b1111, 1'b0);
        // Word B is offered during all of A's frame and must wait for the IDLE cycle
        run_frame("t4_A_1100", 4'b1100, 1, 4'b0101, 1'b1);
        run_frame("t4_B_0101", 4'b0101, 1, 4'b0000, 1'b0);
        reset_mid_frame("t5_rst_1111");
        run_frame("t5_0001", 4'b0001, 1, 4'b1110, 1'b0);
        run_frame("t6_0111", 4'b0111, 2, 4'b1000, 1'b0);
        run_frame("t7_0110", 4'b0110, 1, 4'b1001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
